// File: rtl/myproject_sdiv_pkg.sv
// Shared types and constants for the 22s/6s -> 16s sequential restoring divider.
// Saturating quotient is selected at build time by MYPROJECT_SDIV_SAT_EN.
package myproject_sdiv_pkg;

  localparam int unsigned DIN0_W = 22;
  localparam int unsigned DIN1_W = 6;
  localparam int unsigned DOUT_W = 16;
  localparam int unsigned REM_W  = DIN1_W + 1;
  localparam int unsigned CNT_W  = $clog2(DIN0_W + 1);

  localparam logic [DOUT_W-1:0] QMAX = {1'b0, {(DOUT_W-1){1'b1}}};
  localparam logic [DOUT_W-1:0] QMIN = {1'b1, {(DOUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/myproject_sdiv_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor magnitude.
module myproject_sdiv_step
  import myproject_sdiv_pkg::*;
(
  input  logic [REM_W-1:0]  rem,
  input  logic              din,
  input  logic [DIN1_W-1:0] dmag,
  output logic [REM_W-1:0]  rem_next_c,
  output logic              qbit_c
);

  logic [REM_W:0] shifted;
  logic [REM_W:0] diff;

  always_comb begin
    shifted    = {rem, din};
    diff       = shifted - (REM_W+1)'(dmag);
    qbit_c     = (shifted >= (REM_W+1)'(dmag));
    rem_next_c = REM_W'(qbit_c ? diff : shifted);
  end

endmodule

// File: rtl/myproject_sdiv_22s_6s_16_seq.sv
// Sequential signed divider, one quotient bit per enabled cycle, C truncation semantics.
// Define MYPROJECT_SDIV_SAT_EN to clamp an overflowing quotient instead of wrapping it.
module myproject_sdiv_22s_6s_16_seq
  import myproject_sdiv_pkg::*;
(
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ce,
  input  logic              start,
  input  logic [DIN0_W-1:0] din0,
  input  logic [DIN1_W-1:0] din1,
  output logic              busy,
  output logic              done,
  output logic [DOUT_W-1:0] quotient,
  output logic [DIN1_W-1:0] remainder,
  output logic              ovf,
  output logic              dbz
);

  // Full quotient needs one extra bit: |-2^21 / -1| = 2^21.
  localparam int unsigned     QF_W   = DIN0_W + 1;
  localparam logic [QF_W-1:0] QMAX_X = {{(QF_W-DOUT_W){1'b0}}, QMAX};
  localparam logic [QF_W-1:0] QMIN_X = {{(QF_W-DOUT_W){1'b1}}, QMIN};

  state_t            state;
  state_t            state_next;
  logic              busy_d;
  logic              done_d;
  logic [CNT_W-1:0]  cnt;
  logic [DIN0_W-1:0] dvd;
  logic [REM_W-1:0]  rem;
  logic [REM_W-1:0]  rem_next_c;
  logic              qbit_c;
  logic [DIN1_W-1:0] dmag;
  logic              neg_dvd;
  logic              neg_quo;
  logic              zero_div;
  logic [QF_W-1:0]   qfull_c;
  logic              ovf_c;
  logic [DOUT_W-1:0] quo_c;
  logic [DIN1_W-1:0] rmd_c;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state <= IDLE;
    end else if (ce) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (cnt == CNT_W'(DIN0_W - 1)) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state_next == CALC) || (state_next == FIX);
    done_d = (state_next == DONE);
  end

  myproject_sdiv_step u_step (
    .rem        (rem),
    .din        (dvd[DIN0_W-1]),
    .dmag       (dmag),
    .rem_next_c (rem_next_c),
    .qbit_c     (qbit_c)
  );

  // Sign fix-up, overflow detection and divide-by-zero override.
  always_comb begin
    qfull_c = neg_quo ? (QF_W'(0) - {1'b0, dvd}) : {1'b0, dvd};
    ovf_c   = ($signed(qfull_c) > $signed(QMAX_X)) || ($signed(qfull_c) < $signed(QMIN_X));
`ifdef MYPROJECT_SDIV_SAT_EN
    quo_c   = ovf_c ? (neg_quo ? QMIN : QMAX) : qfull_c[DOUT_W-1:0];
`else
    quo_c   = qfull_c[DOUT_W-1:0];
`endif
    rmd_c   = neg_dvd ? (DIN1_W'(0) - rem[DIN1_W-1:0]) : rem[DIN1_W-1:0];
    if (zero_div) begin
      quo_c = neg_dvd ? QMIN : QMAX;
      rmd_c = '0;
      ovf_c = 1'b0;
    end
  end

  // Dividend register doubles as the quotient shift register.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      cnt       <= '0;
      dvd       <= '0;
      rem       <= '0;
      dmag      <= '0;
      neg_dvd   <= 1'b0;
      neg_quo   <= 1'b0;
      zero_div  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      dbz       <= 1'b0;
    end else if (ce) begin
      busy <= busy_d;
      done <= done_d;
      case (state)
        IDLE: begin
          if (start) begin
            neg_dvd  <= din0[DIN0_W-1];
            neg_quo  <= din0[DIN0_W-1] ^ din1[DIN1_W-1];
            zero_div <= (din1 == '0);
            dvd      <= din0[DIN0_W-1] ? (DIN0_W'(0) - din0) : din0;
            dmag     <= din1[DIN1_W-1] ? (DIN1_W'(0) - din1) : din1;
            rem      <= '0;
            cnt      <= '0;
          end
        end
        CALC: begin
          dvd <= {dvd[DIN0_W-2:0], qbit_c};
          rem <= rem_next_c;
          cnt <= cnt + CNT_W'(1);
        end
        FIX: begin
          quotient  <= quo_c;
          remainder <= rmd_c;
          ovf       <= ovf_c;
          dbz       <= zero_div;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_myproject_sdiv_22s_6s_16_seq.sv
// Scoreboard bench for the sequential signed divider against a C-semantics arithmetic model.
module tb_myproject_sdiv_22s_6s_16_seq;

  typedef struct {
    logic [15:0] q;
    logic [5:0]  r;
    logic        ovf;
    logic        dbz;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        ap_rst;
  logic        ce;
  logic        start;
  logic [21:0] din0;
  logic [5:0]  din1;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [5:0]  remainder;
  logic        ovf;
  logic        dbz;

  int   total = 0;
  int   bad   = 0;
  int   ecnt  = 0;
  exp_t sbq[$];
  exp_t e_mon;
  exp_t e_drop;
  logic dprev = 1'b0;

  myproject_sdiv_22s_6s_16_seq dut (
    .ap_clk    (clk),
    .ap_rst    (ap_rst),
    .ce        (ce),
    .start     (start),
    .din0      (din0),
    .din1      (din1),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf),
    .dbz       (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ecnt <= ecnt + 1;

  // Reference: plain signed division (truncates toward zero, remainder follows dividend).
  function automatic exp_t model(input longint a, input longint b, input int cyc);
    exp_t   e;
    longint q;
    e.cyc = cyc;
    e.ovf = 1'b0;
    e.dbz = 1'b0;
    if (b == 0) begin
      e.dbz = 1'b1;
      e.r   = 6'd0;
      e.q   = (a >= 0) ? 16'h7fff : 16'h8000;
    end else begin
      q     = a / b;
      e.r   = 6'(a % b);
      e.ovf = (q > 32767) || (q < -32768);
`ifdef MYPROJECT_SDIV_SAT_EN
      if (q > 32767)       e.q = 16'h7fff;
      else if (q < -32768) e.q = 16'h8000;
      else                 e.q = 16'(q);
`else
      e.q = 16'(q);
`endif
    end
    return e;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive start for one edge and queue the expected result; lat is the done cycle offset.
  task automatic issue(input logic [21:0] a, input logic [5:0] b, input int lat);
    din0  = a;
    din1  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sbq.push_back(model(longint'($signed(a)), longint'($signed(b)), ecnt + lat));
  endtask

  initial begin
    ap_rst = 1'b1;
    ce     = 1'b1;
    start  = 1'b0;
    din0   = '0;
    din1   = '0;

    fork
      forever begin
        @(negedge clk);
        if (done && !dprev) begin
          if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got done in cycle %0d expected none", ecnt + 1);
          end else begin
            e_mon = sbq.pop_front();
            chk("done_cycle", ecnt + 1, e_mon.cyc);
            chk("quotient", $signed(quotient), $signed(e_mon.q));
            chk("remainder", $signed(remainder), $signed(e_mon.r));
            chk("ovf", ovf, e_mon.ovf);
            chk("dbz", dbz, e_mon.dbz);
          end
        end
        dprev = done;
      end
    join_none

    gap(3);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_dbz", dbz, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    ap_rst = 1'b0;
    gap(2);

    // Directed cases, back to back (next accept 25 edges after the previous).
    issue(22'd1000, 6'd7, 24);               gap(24);
    issue(-22'sd1000, 6'd7, 24);             gap(24);
    issue(22'd1000, -6'sd32, 24);            gap(24);
    issue(-22'sd1000, -6'sd32, 24);          gap(24);
    issue(22'h200000, 6'd1, 24);             gap(24);
    issue(22'd40000, 6'd1, 24);              gap(24);
    issue(22'h200000, -6'sd1, 24);           gap(24);
    issue(22'd500, 6'd0, 24);                gap(24);
    issue(-22'sd5, 6'd0, 24);                gap(24);

    // Second start while busy must be ignored.
    issue(22'd12345, 6'd11, 24);
    gap(4);
    din0  = 22'd777;
    din1  = 6'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_mid_calc", busy, 1);
    gap(19);

    // Reset mid-operation aborts with no done.
    issue(-22'sd99999, 6'd13, 24);
    gap(9);
    ap_rst = 1'b1;
    @(posedge clk);
    #1;
    ap_rst = 1'b0;
    e_drop = sbq.pop_back();
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    gap(30);
    issue(22'd1000, 6'd7, 24);               gap(24);

    // Clock-enable stall of three cycles during CALC.
    issue(-22'sd54321, 6'd9, 27);
    gap(2);
    ce = 1'b0;
    gap(3);
    ce = 1'b1;
    gap(22);

    // Randomized operands; odd iterations keep the dividend in 16-bit range.
    for (int i = 0; i < 40; i++) begin
      logic [21:0] a;
      logic [5:0]  b;
      a = 22'($urandom);
      if (i % 2 == 1) a = 22'($signed(16'($urandom)));
      b = 6'($urandom);
      issue(a, b, 24);
      gap(24);
    end

    gap(40);
    chk("pending_results", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
